branch_predictor: RTL



---
 rtl/branch_predictor.sv | 111 +++++++++++
 1 files changed

// File: rtl/branch_predictor.sv
// Branch target buffer with per-entry saturating direction counters. Fetch looks it up
// every cycle; execute trains it and gets mispredict/redirect and performance counts.
module branch_predictor #(
  parameter int          XLEN      = 32,
  parameter int          ENTRIES   = 16,
  parameter int          CTR_BITS  = 2,
  parameter logic [31:0] STAT_INIT = 32'd0
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [XLEN-1:0] PCF,
  output logic            PredTakenF,
  output logic [XLEN-1:0] PredTargetF,
  input  logic            UpdateE,
  input  logic [XLEN-1:0] PCE,
  input  logic            TakenE,
  input  logic [XLEN-1:0] TargetE,
  input  logic            PredTakenE,
  input  logic [XLEN-1:0] PredTargetE,
  output logic            MispredictE,
  output logic [XLEN-1:0] RedirectPCE,
  output logic [31:0]     BranchCount,
  output logic [31:0]     MispredCount
);
  localparam int IDX  = $clog2(ENTRIES);
  localparam int TAGW = XLEN - IDX - 2;
  localparam logic [CTR_BITS-1:0] CTR_WT   = CTR_BITS'(1'b1) << (CTR_BITS - 1);
  localparam logic [CTR_BITS-1:0] CTR_WNT  = CTR_WT - CTR_BITS'(1'b1);
  localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};
  localparam logic [CTR_BITS-1:0] CTR_MIN  = {CTR_BITS{1'b0}};
  localparam logic [31:0]         STAT_MAX = 32'hFFFF_FFFF;

  logic                validR  [ENTRIES];
  logic [TAGW-1:0]     tagR    [ENTRIES];
  logic [XLEN-1:0]     targetR [ENTRIES];
  logic [CTR_BITS-1:0] ctrR    [ENTRIES];

  logic [IDX-1:0]  fIdxS;
  logic [IDX-1:0]  eIdxS;
  logic [TAGW-1:0] fTagS;
  logic [TAGW-1:0] eTagS;
  logic            fHitS;
  logic            eHitS;
  logic            mispredS;
  logic [XLEN-1:0] pcfPlus4S;
  logic [XLEN-1:0] pcePlus4S;

  function automatic logic [CTR_BITS-1:0] ctrNext(input logic [CTR_BITS-1:0] ctr,
                                                  input logic taken);
    logic [CTR_BITS-1:0] nxt;
    if (taken) begin
      if (ctr == CTR_MAX) nxt = ctr;
      else                nxt = ctr + CTR_BITS'(1'b1);
    end else begin
      if (ctr == CTR_MIN) nxt = ctr;
      else                nxt = ctr - CTR_BITS'(1'b1);
    end
    return nxt;
  endfunction

  assign fIdxS     = PCF[IDX+1:2];
  assign fTagS     = PCF[XLEN-1:IDX+2];
  assign eIdxS     = PCE[IDX+1:2];
  assign eTagS     = PCE[XLEN-1:IDX+2];
  assign pcfPlus4S = PCF + XLEN'(32'd4);
  assign pcePlus4S = PCE + XLEN'(32'd4);

  // Lookup reads pre-update state only; there is deliberately no bypass from execute.
  assign fHitS       = validR[fIdxS] && (tagR[fIdxS] == fTagS);
  assign PredTakenF  = fHitS && ctrR[fIdxS][CTR_BITS-1];
  assign PredTargetF = PredTakenF ? targetR[fIdxS] : pcfPlus4S;

  assign eHitS       = validR[eIdxS] && (tagR[eIdxS] == eTagS);
  assign mispredS    = UpdateE && ((PredTakenE != TakenE) ||
                                   (TakenE && PredTakenE && (PredTargetE != TargetE)));
  assign MispredictE = mispredS;
  assign RedirectPCE = TakenE ? TargetE : pcePlus4S;

  // BTB entry training: counter update on hit, allocation on a taken miss.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < ENTRIES; i++) begin
        validR[i]  <= 1'b0;
        tagR[i]    <= {TAGW{1'b0}};
        targetR[i] <= {XLEN{1'b0}};
        ctrR[i]    <= CTR_WNT;
      end
    end else if (UpdateE) begin
      if (eHitS) begin
        ctrR[eIdxS] <= ctrNext(ctrR[eIdxS], TakenE);
        if (TakenE) targetR[eIdxS] <= TargetE;
      end else if (TakenE) begin
        validR[eIdxS]  <= 1'b1;
        tagR[eIdxS]    <= eTagS;
        targetR[eIdxS] <= TargetE;
        ctrR[eIdxS]    <= CTR_WT;
      end
    end
  end

  // Performance counters, saturating at all-ones rather than wrapping.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      BranchCount  <= STAT_INIT;
      MispredCount <= STAT_INIT;
    end else begin
      if (UpdateE && (BranchCount != STAT_MAX))   BranchCount  <= BranchCount + 32'd1;
      if (mispredS && (MispredCount != STAT_MAX)) MispredCount <= MispredCount + 32'd1;
    end
  end
endmodule
